turn_controller: RTL

Parametrised game-flow controller for the board-game top level. It sequences board initialisation, rendering, cursor movement, piece and destination selection, move validation, win detection and memory update. Board size, piece encoding, player count and cursor repeat rate are configurable. Compared with the previous controller it adds:
- piece-ownership checking;
- a real validator handshake with timeout;
- a saturating cursor and a move counter;
- restart from game-over without reset.

---
 rtl/turn_controller.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/turn_controller.sv
// Game-flow controller: board init, rendering, cursor, piece/destination
// selection, validator handshake with timeout, win detection and move commit.
module turn_controller #(
  parameter int COORD_W           = 3,
  parameter int PIECE_W           = 4,
  parameter int PIECES_PER_PLAYER = 6,
  parameter int NUM_PLAYERS       = 2,
  parameter int REPEAT_CYCLES     = 50000000,
  parameter int VAL_TIMEOUT       = 1024,
  localparam int PLAYER_W         = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 up,
  input  logic                 down,
  input  logic                 left,
  input  logic                 right,
  input  logic                 select,
  input  logic                 deselect,
  input  logic [PIECE_W-1:0]   piece_read,
  input  logic                 init_done,
  input  logic                 render_done,
  input  logic                 move_done,
  input  logic                 val_done,
  input  logic                 val_ok,
  output logic [1:0]           mem_grant,
  output logic [2*COORD_W-1:0] mem_addr,
  output logic                 start_init,
  output logic                 start_render,
  output logic                 start_validate,
  output logic                 start_move,
  output logic [COORD_W-1:0]   box_x,
  output logic [COORD_W-1:0]   box_y,
  output logic                 box_moved,
  output logic [COORD_W-1:0]   origin_x,
  output logic [COORD_W-1:0]   origin_y,
  output logic [COORD_W-1:0]   dest_x,
  output logic [COORD_W-1:0]   dest_y,
  output logic [PIECE_W-1:0]   piece_to_move,
  output logic [PLAYER_W-1:0]  current_player,
  output logic                 game_over,
  output logic [PLAYER_W-1:0]  winner,
  output logic [15:0]          move_count,
  output logic [3:0]           state
);

  localparam int RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam int VT_W  = (VAL_TIMEOUT > 1) ? $clog2(VAL_TIMEOUT) : 1;
  localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_CYCLES - 1);
  localparam logic [VT_W-1:0]  VT_LAST    = VT_W'(VAL_TIMEOUT - 1);
  localparam int unsigned PPP = PIECES_PER_PLAYER;
  localparam int unsigned NP  = NUM_PLAYERS;

  typedef enum logic [3:0] {
    S_INIT        = 4'd0,
    S_INIT_WAIT   = 4'd1,
    S_RENDER      = 4'd2,
    S_RENDER_WAIT = 4'd3,
    S_PICK        = 4'd4,
    S_CHECK_PIECE = 4'd5,
    S_DEST        = 4'd6,
    S_VAL         = 4'd7,
    S_VAL_WAIT    = 4'd8,
    S_WIN         = 4'd9,
    S_MOVE        = 4'd10,
    S_MOVE_WAIT   = 4'd11,
    S_OVER        = 4'd12
  } state_t;

  state_t              state_q, state_d;
  logic [COORD_W-1:0]  box_x_q, box_x_d, box_y_q, box_y_d;
  logic                box_moved_q, box_moved_d;
  logic [RPT_W-1:0]    rpt_q, rpt_d;
  logic [COORD_W-1:0]  origin_x_q, origin_x_d, origin_y_q, origin_y_d;
  logic [COORD_W-1:0]  dest_x_q, dest_x_d, dest_y_q, dest_y_d;
  logic [PIECE_W-1:0]  piece_to_move_q, piece_to_move_d;
  logic [PIECE_W-1:0]  dest_piece_q, dest_piece_d;
  logic [PLAYER_W-1:0] current_player_q, current_player_d;
  logic [PLAYER_W-1:0] winner_q, winner_d;
  logic [15:0]         move_count_q, move_count_d;
  logic [VT_W-1:0]     val_cnt_q, val_cnt_d;
  logic                sel_prev_q, desel_prev_q;

  logic sel_edge, desel_edge, cursor_en, held, piece_legal, enemy_king;

  assign sel_edge   = select & ~sel_prev_q;
  assign desel_edge = deselect & ~desel_prev_q;
  assign cursor_en  = (state_q == S_PICK) || (state_q == S_DEST);
  assign held       = cursor_en && (up || down || left || right);

  // Ownership of the origin piece and enemy-king test on the destination piece
  always_comb begin
    int unsigned cur, code_o, code_d;
    cur         = 32'(current_player_q);
    code_o      = 32'(piece_to_move_q);
    code_d      = 32'(dest_piece_q);
    piece_legal = (code_o != 0) && (code_o >= cur * PPP + 1) && (code_o <= (cur + 1) * PPP);
    enemy_king  = 1'b0;
    for (int unsigned p = 0; p < NP; p++) begin
      if (p != cur && code_d == (p + 1) * PPP) enemy_king = 1'b1;
    end
  end

  // Cursor with hold-to-repeat timer; each axis saturates independently
  always_comb begin
    box_x_d = box_x_q;
    box_y_d = box_y_q;
    rpt_d   = rpt_q;
    if (!held) begin
      rpt_d = '0;
    end else if (rpt_q == '0) begin
      rpt_d = RPT_RELOAD;
      if (right && !left && box_x_q != '1)      box_x_d = box_x_q + 1'b1;
      else if (left && !right && box_x_q != '0) box_x_d = box_x_q - 1'b1;
      if (up && !down && box_y_q != '1)         box_y_d = box_y_q + 1'b1;
      else if (down && !up && box_y_q != '0)    box_y_d = box_y_q - 1'b1;
    end else begin
      rpt_d = rpt_q - 1'b1;
    end
    box_moved_d = (box_x_d != box_x_q) || (box_y_d != box_y_q);
  end

  // Game-flow next state and latched selection/score registers
  always_comb begin
    state_d          = state_q;
    origin_x_d       = origin_x_q;
    origin_y_d       = origin_y_q;
    dest_x_d         = dest_x_q;
    dest_y_d         = dest_y_q;
    piece_to_move_d  = piece_to_move_q;
    dest_piece_d     = dest_piece_q;
    current_player_d = current_player_q;
    winner_d         = winner_q;
    move_count_d     = move_count_q;
    val_cnt_d        = val_cnt_q;
    case (state_q)
      S_INIT:        state_d = S_INIT_WAIT;
      S_INIT_WAIT:   if (init_done) state_d = S_RENDER;
      S_RENDER:      state_d = S_RENDER_WAIT;
      S_RENDER_WAIT: if (render_done) state_d = S_PICK;
      S_PICK: begin
        if (sel_edge) begin
          origin_x_d      = box_x_q;
          origin_y_d      = box_y_q;
          piece_to_move_d = piece_read;
          state_d         = S_CHECK_PIECE;
        end
      end
      S_CHECK_PIECE: state_d = piece_legal ? S_DEST : S_PICK;
      S_DEST: begin
        if (desel_edge) begin
          state_d = S_PICK;
        end else if (sel_edge) begin
          dest_x_d     = box_x_q;
          dest_y_d     = box_y_q;
          dest_piece_d = piece_read;
          state_d      = (box_x_q == origin_x_q && box_y_q == origin_y_q) ? S_PICK : S_VAL;
        end
      end
      S_VAL: begin
        val_cnt_d = '0;
        state_d   = S_VAL_WAIT;
      end
      S_VAL_WAIT: begin
        if (val_done)                state_d = val_ok ? S_WIN : S_DEST;
        else if (val_cnt_q == VT_LAST) state_d = S_DEST;
        else                         val_cnt_d = val_cnt_q + 1'b1;
      end
      S_WIN: begin
        if (enemy_king) begin
          winner_d = current_player_q;
          state_d  = S_OVER;
        end else begin
          state_d = S_MOVE;
        end
      end
      S_MOVE:        state_d = S_MOVE_WAIT;
      S_MOVE_WAIT: begin
        if (move_done) begin
          if (move_count_q != '1) move_count_d = move_count_q + 1'b1;
          current_player_d = (current_player_q == PLAYER_W'(NUM_PLAYERS - 1)) ? '0
                           : current_player_q + 1'b1;
          state_d = S_RENDER;
        end
      end
      S_OVER: begin
        // A restarted game begins afresh with player 0 and no moves on record.
        if (sel_edge) begin
          current_player_d = '0;
          move_count_d     = '0;
          state_d          = S_INIT;
        end
      end
      default:       state_d = S_INIT;
    endcase
  end

  // Register update with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q          <= S_INIT;
      box_x_q          <= '0;
      box_y_q          <= '0;
      box_moved_q      <= 1'b0;
      rpt_q            <= '0;
      origin_x_q       <= '0;
      origin_y_q       <= '0;
      dest_x_q         <= '0;
      dest_y_q         <= '0;
      piece_to_move_q  <= '0;
      dest_piece_q     <= '0;
      current_player_q <= '0;
      winner_q         <= '0;
      move_count_q     <= '0;
      val_cnt_q        <= '0;
      sel_prev_q       <= 1'b0;
      desel_prev_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      box_x_q          <= box_x_d;
      box_y_q          <= box_y_d;
      box_moved_q      <= box_moved_d;
      rpt_q            <= rpt_d;
      origin_x_q       <= origin_x_d;
      origin_y_q       <= origin_y_d;
      dest_x_q         <= dest_x_d;
      dest_y_q         <= dest_y_d;
      piece_to_move_q  <= piece_to_move_d;
      dest_piece_q     <= dest_piece_d;
      current_player_q <= current_player_d;
      winner_q         <= winner_d;
      move_count_q     <= move_count_d;
      val_cnt_q        <= val_cnt_d;
      sel_prev_q       <= select;
      desel_prev_q     <= deselect;
    end
  end

  // Memory ownership follows the waiting state
  always_comb begin
    mem_grant = 2'd0;
    case (state_q)
      S_INIT_WAIT, S_MOVE_WAIT: mem_grant = 2'd2;
      S_RENDER_WAIT:            mem_grant = 2'd3;
      S_VAL_WAIT:               mem_grant = 2'd1;
      default:                  mem_grant = 2'd0;
    endcase
  end

  assign mem_addr       = {box_y_q, box_x_q};
  assign start_init     = (state_q == S_INIT);
  assign start_render   = (state_q == S_RENDER);
  assign start_validate = (state_q == S_VAL);
  assign start_move     = (state_q == S_MOVE);
  assign box_x          = box_x_q;
  assign box_y          = box_y_q;
  assign box_moved      = box_moved_q;
  assign origin_x       = origin_x_q;
  assign origin_y       = origin_y_q;
  assign dest_x         = dest_x_q;
  assign dest_y         = dest_y_q;
  assign piece_to_move  = piece_to_move_q;
  assign current_player = current_player_q;
  assign game_over      = (state_q == S_OVER);
  assign winner         = winner_q;
  assign move_count     = move_count_q;
  assign state          = state_q;

endmodule
